// File: rtl/seg_scan_pkg.sv
// Shared definitions for the seven-segment scan driver and its upstream decoders.
// All segment and anode values are active-low.
package seg_scan_pkg;

  localparam int          NUM_DIGITS = 4;
  localparam logic [7:0]  SEG_OFF    = 8'hFF;
  localparam logic [3:0]  AN_OFF     = 4'hF;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_t;

  // Hex glyphs with the decimal point off; bit 7 = dp, bits 6..0 = g..a.
  localparam logic [7:0] HEX_0 = 8'hC0;
  localparam logic [7:0] HEX_1 = 8'hF9;
  localparam logic [7:0] HEX_2 = 8'hA4;
  localparam logic [7:0] HEX_3 = 8'hB0;
  localparam logic [7:0] HEX_4 = 8'h99;
  localparam logic [7:0] HEX_5 = 8'h92;
  localparam logic [7:0] HEX_6 = 8'h82;
  localparam logic [7:0] HEX_7 = 8'hF8;
  localparam logic [7:0] HEX_8 = 8'h80;
  localparam logic [7:0] HEX_9 = 8'h90;
  localparam logic [7:0] HEX_A = 8'h88;
  localparam logic [7:0] HEX_B = 8'h83;
  localparam logic [7:0] HEX_C = 8'hC6;
  localparam logic [7:0] HEX_D = 8'hA1;
  localparam logic [7:0] HEX_E = 8'h86;
  localparam logic [7:0] HEX_F = 8'h8E;

  function automatic logic [7:0] hex_to_seg(input logic [3:0] v);
    logic [7:0] s;
    s = SEG_OFF;
    case (v)
      4'h0: s = HEX_0;
      4'h1: s = HEX_1;
      4'h2: s = HEX_2;
      4'h3: s = HEX_3;
      4'h4: s = HEX_4;
      4'h5: s = HEX_5;
      4'h6: s = HEX_6;
      4'h7: s = HEX_7;
      4'h8: s = HEX_8;
      4'h9: s = HEX_9;
      4'hA: s = HEX_A;
      4'hB: s = HEX_B;
      4'hC: s = HEX_C;
      4'hD: s = HEX_D;
      4'hE: s = HEX_E;
      default: s = HEX_F;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg_scan_driver_timer.sv
// Slot counter and digit index for the scan driver; flags the last cycle of
// each digit slot and of the whole frame.
module scan_timer #(
  parameter int DIGIT_TICKS = 100000,
  parameter int CW          = $clog2(DIGIT_TICKS)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [CW-1:0] cnt_o,
  output logic [1:0]    idx_o,
  output logic          slot_end_o,
  output logic          frame_end_o
);

  localparam logic [CW-1:0] CNT_MAX = CW'(DIGIT_TICKS - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic          slot_end;

  always_comb begin
    slot_end = (cnt_q == CNT_MAX);
    cnt_d    = slot_end ? '0 : cnt_q + CW'(1);
    idx_d    = slot_end ? idx_q + 2'd1 : idx_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  assign cnt_o       = cnt_q;
  assign idx_o       = idx_q;
  assign slot_end_o  = slot_end;
  assign frame_end_o = slot_end && (idx_q == 2'd3);

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment driver with per-slot blanking and a
// once-per-frame input snapshot so the image never tears mid-frame.
module seg_scan_driver
  import seg_scan_pkg::*;
#(
  parameter int DIGIT_TICKS = 100000,
  parameter int BLANK_TICKS = 2000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] digit_seg,
  input  logic [3:0]  digit_en,
  output logic [7:0]  seg,
  output logic [3:0]  an,
  output logic        frame_tick,
  output scan_state_t dbg_state
);

  localparam int            CW         = $clog2(DIGIT_TICKS);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_TICKS - 1);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic          slot_end, frame_end;

  scan_timer #(
    .DIGIT_TICKS (DIGIT_TICKS),
    .CW          (CW)
  ) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .cnt_o       (cnt),
    .idx_o       (idx),
    .slot_end_o  (slot_end),
    .frame_end_o (frame_end)
  );

  scan_state_t state_q, state_d;
  logic [31:0] sh_seg_q, sh_seg_d;
  logic [3:0]  sh_en_q, sh_en_d;
  logic [7:0]  seg_q, seg_d;
  logic [3:0]  an_q, an_d;
  logic        frame_tick_q, frame_tick_d;
  logic [4:0]  byte_lsb;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BLANK: if (cnt == BLANK_LAST) state_d = ST_SHOW;
      ST_SHOW:  if (slot_end)          state_d = ST_BLANK;
      default:                         state_d = ST_BLANK;
    endcase
  end

  // The snapshot edge always lands in blanking, so the shown image is stable.
  always_comb begin
    sh_seg_d = sh_seg_q;
    sh_en_d  = sh_en_q;
    if (idx == 2'd0 && cnt == '0) begin
      sh_seg_d = digit_seg;
      sh_en_d  = digit_en;
    end
  end

  always_comb begin
    byte_lsb     = {idx, 3'b000};
    seg_d        = SEG_OFF;
    an_d         = AN_OFF;
    frame_tick_d = frame_end;
    if (state_q == ST_SHOW && sh_en_q[idx]) begin
      an_d  = ~(4'b0001 << idx);
      seg_d = sh_seg_q[byte_lsb +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_BLANK;
      sh_seg_q     <= 32'hFFFF_FFFF;
      sh_en_q      <= 4'h0;
      seg_q        <= SEG_OFF;
      an_q         <= AN_OFF;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sh_seg_q     <= sh_seg_d;
      sh_en_q      <= sh_en_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_tick = frame_tick_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with DIGIT_TICKS=8, BLANK_TICKS=2.
module tb_seg_scan_driver;
  import seg_scan_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] digit_seg;
  logic [3:0]  digit_en;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_tick;
  scan_state_t dbg_state;

  seg_scan_driver #(
    .DIGIT_TICKS (8),
    .BLANK_TICKS (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .digit_seg  (digit_seg),
    .digit_en   (digit_en),
    .seg        (seg),
    .an         (an),
    .frame_tick (frame_tick),
    .dbg_state  (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_err    = 0;
  int          k        = 0;
  int          ft_count = 0;
  int          last_ft  = -1;
  logic [31:0] exp_sh_seg = 32'hFFFF_FFFF;
  logic [3:0]  exp_sh_en  = 4'h0;
  logic [3:0]  prev_an;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s edge=%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  // Advance one clock edge and compare outputs with the expected scan position.
  task automatic step();
    int         c;
    int         d;
    logic [3:0] exp_an;
    logic [7:0] exp_seg;
    logic       exp_ft;
    if (k % 32 == 0) begin
      exp_sh_seg = digit_seg;
      exp_sh_en  = digit_en;
    end
    prev_an = an;
    @(negedge clk);
    k++;
    c       = (k - 1) % 8;
    d       = ((k - 1) / 8) % 4;
    exp_an  = 4'hF;
    exp_seg = 8'hFF;
    if (c >= 2 && exp_sh_en[d]) begin
      exp_an  = ~(4'b0001 << d);
      exp_seg = exp_sh_seg[8*d +: 8];
    end
    exp_ft = (c == 7 && d == 3);
    check("an", {28'd0, an}, {28'd0, exp_an});
    check("seg", {24'd0, seg}, {24'd0, exp_seg});
    check("frame_tick", {31'd0, frame_tick}, {31'd0, exp_ft});
    if (prev_an != 4'hF && an != 4'hF) check("blank_gap", {28'd0, an}, {28'd0, prev_an});
    if (frame_tick) begin
      ft_count++;
      if (last_ft >= 0) check("ft_spacing", k - last_ft, 32);
      last_ft = k;
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    digit_seg = 32'hC0F9A4B0;
    digit_en  = 4'hF;

    repeat (5) begin
      @(negedge clk);
      check("rst_seg", {24'd0, seg}, 32'h0000_00FF);
      check("rst_an", {28'd0, an}, 32'h0000_000F);
      check("rst_ft", {31'd0, frame_tick}, 32'd0);
    end
    rst_n = 1'b1;

    // Frame 1: full scan; digit 0 lights after edge 3.
    repeat (2) step();
    check("d0_blank_edge2", {28'd0, an}, 32'h0000_000F);
    step();
    check("d0_lit_edge3", {28'd0, an}, 32'h0000_000E);
    check("d0_seg_edge3", {24'd0, seg}, 32'h0000_00B0);
    repeat (29) step();
    check("ft_count_f1", ft_count, 1);

    // Frame 2: byte 0 changes during the digit-2 slot and must not show yet.
    repeat (20) step();
    digit_seg = 32'hC0F9A480;
    repeat (12) step();

    // Frame 3: the new byte 0 appears.
    repeat (3) step();
    check("tear_new_d0", {24'd0, seg}, 32'h0000_0080);
    repeat (29) step();
    check("ft_count_f3", ft_count, 3);

    // Frame 4: only digits 0 and 2 enabled.
    digit_en = 4'b0101;
    repeat (11) step();
    check("mask_d1_off", {28'd0, an}, 32'h0000_000F);
    repeat (21) step();

    // Frame 5: everything disabled, frame_tick still pulses.
    digit_en = 4'h0;
    repeat (32) step();
    check("ft_count_f5", ft_count, 5);

    // Frame 6: asynchronous reset while digit 2 is lit.
    digit_en = 4'hF;
    repeat (21) step();
    check("pre_reset_an", {28'd0, an}, 32'h0000_000B);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_an", {28'd0, an}, 32'h0000_000F);
    check("async_seg", {24'd0, seg}, 32'h0000_00FF);
    check("async_ft", {31'd0, frame_tick}, 32'd0);
    @(negedge clk);
    k          = 0;
    last_ft    = -1;
    exp_sh_seg = 32'hFFFF_FFFF;
    exp_sh_en  = 4'h0;
    rst_n      = 1'b1;
    repeat (2) step();
    check("restart_blank", {28'd0, an}, 32'h0000_000F);
    step();
    check("restart_first_lit", {28'd0, an}, 32'h0000_000E);
    repeat (5) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
